// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: pipeline/CSR-facing signals of trap_ctrl.
// master = trap_ctrl side, slave = pipeline and CSR file side.
interface trap_ctrl_if;
    logic [31:0] pc;
    logic        ei_n;
    logic        ti_n;
    logic        exc_ecall;
    logic        exc_ebreak;
    logic        mret_req;
    logic        pipe_idle;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie_meie;
    logic        mie_mtie;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        mepc_we;
    logic [31:0] mepc_wdata;
    logic        mcause_we;
    logic [31:0] mcause_wdata;
    logic        mstatus_we;
    logic        mie_wdata;
    logic        mpie_wdata;
    logic        busy;

    modport master (
        input  pc, ei_n, ti_n, exc_ecall, exc_ebreak, mret_req, pipe_idle,
        input  mtvec, mepc, mie_meie, mie_mtie, mstatus_mie, mstatus_mpie,
        output stall, redirect_valid, redirect_addr,
        output mepc_we, mepc_wdata, mcause_we, mcause_wdata,
        output mstatus_we, mie_wdata, mpie_wdata, busy
    );

    modport slave (
        output pc, ei_n, ti_n, exc_ecall, exc_ebreak, mret_req, pipe_idle,
        output mtvec, mepc, mie_meie, mie_mtie, mstatus_mie, mstatus_mpie,
        input  stall, redirect_valid, redirect_addr,
        input  mepc_we, mepc_wdata, mcause_we, mcause_wdata,
        input  mstatus_we, mie_wdata, mpie_wdata, busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitration, drain, CSR save, PC redirect.
// Define TRAP_VECTORED_EN for vectored interrupt dispatch (mtvec[1:0]==01).
module trap_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DRAIN = 3'd1;
    localparam logic [2:0] SAVE  = 3'd2;
    localparam logic [2:0] JUMP  = 3'd3;
    localparam logic [2:0] RET   = 3'd4;

    localparam logic [31:0] C_ECALL  = 32'h0000_000B;
    localparam logic [31:0] C_EBREAK = 32'h0000_0003;
    localparam logic [31:0] C_TIMER  = 32'h8000_0007;
    localparam logic [31:0] C_EXT    = 32'h8000_000B;

    logic [2:0]  state;
    logic [2:0]  nxt;
    logic [31:0] cause;
    logic [31:0] nxt_cause;
    logic [31:0] epc;
    logic [31:0] last_addr;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic        ei_s1, ei_s2;
    logic        ti_s1, ti_s2;
    logic        ip_e, ip_t;
    logic        take_trap;
    logic        unused_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ei_s1 <= 1'b1;
            ei_s2 <= 1'b1;
            ti_s1 <= 1'b1;
            ti_s2 <= 1'b1;
        end else begin
            ei_s1 <= bus.ei_n;
            ei_s2 <= ei_s1;
            ti_s1 <= bus.ti_n;
            ti_s2 <= ti_s1;
        end
    end

    assign ip_e = ~ei_s2 & bus.mie_meie & bus.mstatus_mie;
    assign ip_t = ~ti_s2 & bus.mie_mtie & bus.mstatus_mie;

    always_comb begin
        nxt       = state;
        nxt_cause = cause;
        take_trap = 1'b0;
        case (state)
            IDLE: begin
                if (bus.exc_ecall) begin
                    nxt_cause = C_ECALL;
                    take_trap = 1'b1;
                end else if (bus.exc_ebreak) begin
                    nxt_cause = C_EBREAK;
                    take_trap = 1'b1;
                end else if (bus.mret_req) begin
                    nxt = RET;
                end else if (ip_t) begin
                    nxt_cause = C_TIMER;
                    take_trap = 1'b1;
                end else if (ip_e) begin
                    nxt_cause = C_EXT;
                    take_trap = 1'b1;
                end
                if (take_trap) nxt = DRAIN;
            end
            DRAIN:   if (bus.pipe_idle) nxt = SAVE;
            SAVE:    nxt = JUMP;
            JUMP:    nxt = IDLE;
            RET:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cause <= '0;
            epc   <= '0;
        end else begin
            state <= nxt;
            if (take_trap) begin
                cause <= nxt_cause;
                epc   <= {bus.pc[31:2], 2'b00};
            end
        end
    end

    assign trap_base = {bus.mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Only interrupts are vectored; synchronous exceptions land on the base.
    assign trap_target = (bus.mtvec[1:0] == 2'b01 && cause[31])
                       ? trap_base + {25'd0, cause[4:0], 2'b00}
                       : trap_base;
    assign unused_ok   = ^bus.pc[1:0];
`else
    assign trap_target = trap_base;
    assign unused_ok   = ^{bus.pc[1:0], bus.mtvec[1:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_addr <= RESET_VEC;
        else if (bus.redirect_valid) last_addr <= bus.redirect_addr;
    end

    assign bus.busy           = (state != IDLE);
    assign bus.stall          = (state != IDLE);
    assign bus.mepc_we        = (state == SAVE);
    assign bus.mcause_we      = (state == SAVE);
    assign bus.mstatus_we     = (state == SAVE) || (state == RET);
    assign bus.redirect_valid = (state == JUMP) || (state == RET);
    assign bus.mepc_wdata     = epc;
    assign bus.mcause_wdata   = cause;
    assign bus.mie_wdata      = (state == RET) & bus.mstatus_mpie;
    assign bus.mpie_wdata     = ((state == SAVE) & bus.mstatus_mie)
                              | (state == RET);
    assign bus.redirect_addr  = (state == JUMP) ? trap_target
                              : (state == RET)  ? bus.mepc
                              : last_addr;
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: CSR-write and redirect events checked in order.
module tb_trap_ctrl;
    localparam logic [31:0] RV = 32'hDEAD_0000;
    localparam logic [1:0] K_SAVE = 2'd0;
    localparam logic [1:0] K_JUMP = 2'd1;
    localparam logic [1:0] K_RET  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] c;
        logic        mie;
        logic        mpie;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t q[$];

    trap_ctrl_if b();

    trap_ctrl #(.RESET_VEC(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_save(input logic [31:0] a, input logic [31:0] c,
                             input logic mpie);
        q.push_back('{K_SAVE, a, c, 1'b0, mpie});
    endtask

    task automatic push_jump(input logic [31:0] a);
        q.push_back('{K_JUMP, a, 32'd0, 1'b0, 1'b0});
    endtask

    task automatic push_ret(input logic [31:0] a, input logic mie);
        q.push_back('{K_RET, a, 32'd0, mie, 1'b1});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((b.busy || q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (b.mepc_we || b.mcause_we || b.mstatus_we
                     || b.redirect_valid)) begin
            if (q.size() == 0) begin
                chk("unexp_evt", 1, 0);
            end else begin
                exp_t e;
                logic [1:0] k;
                e = q.pop_front();
                k = (b.redirect_valid && b.mstatus_we) ? K_RET
                  : b.redirect_valid ? K_JUMP : K_SAVE;
                chk("kind", 32'(k), 32'(e.kind));
                case (e.kind)
                    K_SAVE: begin
                        chk("save_we", {29'd0, b.mepc_we, b.mcause_we,
                            b.mstatus_we}, 32'd7);
                        chk("mepc", b.mepc_wdata, e.a);
                        chk("mcause", b.mcause_wdata, e.c);
                        chk("save_mie", 32'(b.mie_wdata), 32'(e.mie));
                        chk("save_mpie", 32'(b.mpie_wdata), 32'(e.mpie));
                    end
                    K_JUMP: begin
                        chk("jump_addr", b.redirect_addr, e.a);
                        chk("jump_stall", 32'(b.stall), 1);
                    end
                    default: begin
                        chk("ret_addr", b.redirect_addr, e.a);
                        chk("ret_mie", 32'(b.mie_wdata), 32'(e.mie));
                        chk("ret_mpie", 32'(b.mpie_wdata), 32'(e.mpie));
                    end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && b.busy && (b.exc_ecall || b.exc_ebreak || b.mret_req))
            chk("stim_in_busy", 1, 0);
    end

    initial begin
        logic [31:0] ext_target;
        b.pc = 32'h0;
        b.ei_n = 1'b1;
        b.ti_n = 1'b1;
        b.exc_ecall = 1'b0;
        b.exc_ebreak = 1'b0;
        b.mret_req = 1'b0;
        b.pipe_idle = 1'b1;
        b.mtvec = 32'h100;
        b.mepc = 32'h0;
        b.mie_meie = 1'b0;
        b.mie_mtie = 1'b0;
        b.mstatus_mie = 1'b1;
        b.mstatus_mpie = 1'b0;
        repeat (3) step();
        chk("rst_stall", 32'(b.stall), 0);
        chk("rst_busy", 32'(b.busy), 0);
        chk("rst_redir", 32'(b.redirect_valid), 0);
        chk("rst_addr", b.redirect_addr, RV);
        chk("rst_we", {29'd0, b.mepc_we, b.mcause_we, b.mstatus_we}, 0);
        chk("rst_wdata", {30'd0, b.mie_wdata, b.mpie_wdata}, 0);
        rst = 1'b0;
        step();

        // ecall, pipeline already idle
        b.pc = 32'h206;
        b.exc_ecall = 1'b1;
        push_save(32'h204, 32'hB, 1'b1);
        push_jump(32'h100);
        step();
        b.exc_ecall = 1'b0;
        chk("ecall_stall_n1", 32'(b.stall), 1);
        chk("ecall_busy_n1", 32'(b.busy), 1);
        step();
        chk("ecall_save_n2", 32'(b.mepc_we), 1);
        step();
        chk("ecall_redir_n3", 32'(b.redirect_valid), 1);
        step();
        chk("ecall_stall_n4", 32'(b.stall), 0);
        wait_done(10);

        // timer interrupt with a slow drain
        b.pc = 32'h300;
        b.mie_mtie = 1'b1;
        b.pipe_idle = 1'b0;
        b.ti_n = 1'b0;
        push_save(32'h300, 32'h8000_0007, 1'b1);
        push_jump(32'h100);
        step();
        chk("tmr_sync1", 32'(b.busy), 0);
        step();
        chk("tmr_sync2", 32'(b.busy), 0);
        step();
        chk("tmr_taken", 32'(b.busy), 1);
        b.ti_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_stall", 32'(b.stall), 1);
            chk("drain_no_we", 32'(b.mepc_we), 0);
            step();
        end
        b.pipe_idle = 1'b1;
        wait_done(10);

        // timer beats external
        b.pc = 32'h400;
        b.mie_meie = 1'b1;
        b.ei_n = 1'b0;
        b.ti_n = 1'b0;
        push_save(32'h400, 32'h8000_0007, 1'b1);
        push_jump(32'h100);
        repeat (3) step();
        chk("both_taken", 32'(b.busy), 1);
        b.ei_n = 1'b1;
        b.ti_n = 1'b1;
        wait_done(10);
        repeat (3) step();
        chk("both_quiet", 32'(b.busy), 0);

        // mret
        b.mepc = 32'h3C0;
        b.mstatus_mpie = 1'b1;
        b.mret_req = 1'b1;
        push_ret(32'h3C0, 1'b1);
        step();
        b.mret_req = 1'b0;
        chk("mret_redir_n1", 32'(b.redirect_valid), 1);
        chk("mret_stall_n1", 32'(b.stall), 1);
        step();
        chk("mret_idle_n2", 32'(b.busy), 0);
        wait_done(5);

        // mret and pending timer in the same cycle
        b.mie_meie = 1'b0;
        b.pc = 32'h500;
        b.mstatus_mpie = 1'b0;
        b.ti_n = 1'b0;
        step();
        step();
        b.mret_req = 1'b1;
        push_ret(32'h3C0, 1'b0);
        push_save(32'h500, 32'h8000_0007, 1'b1);
        push_jump(32'h100);
        step();
        b.mret_req = 1'b0;
        chk("mix_ret_first", 32'(b.redirect_valid), 1);
        b.ti_n = 1'b1;
        step();
        chk("mix_idle", 32'(b.busy), 0);
        step();
        chk("mix_irq_after", 32'(b.busy), 1);
        wait_done(10);
        repeat (3) step();

        // vectored mtvec: ebreak uses base, external may vector
`ifdef TRAP_VECTORED_EN
        ext_target = 32'h12C;
`else
        ext_target = 32'h100;
`endif
        b.mtvec = 32'h101;
        b.mie_mtie = 1'b0;
        b.pc = 32'h600;
        b.exc_ebreak = 1'b1;
        push_save(32'h600, 32'h3, 1'b1);
        push_jump(32'h100);
        step();
        b.exc_ebreak = 1'b0;
        wait_done(10);
        b.mie_meie = 1'b1;
        b.pc = 32'h700;
        b.ei_n = 1'b0;
        push_save(32'h700, 32'h8000_000B, 1'b1);
        push_jump(ext_target);
        repeat (3) step();
        chk("ext_taken", 32'(b.busy), 1);
        b.ei_n = 1'b1;
        wait_done(10);
        repeat (3) step();
        b.mtvec = 32'h100;

        // reset while draining: nothing may complete
        b.pipe_idle = 1'b0;
        b.pc = 32'h800;
        b.exc_ecall = 1'b1;
        step();
        b.exc_ecall = 1'b0;
        chk("rd_busy", 32'(b.busy), 1);
        step();
        rst = 1'b1;
        #1;
        chk("rd_stall", 32'(b.stall), 0);
        chk("rd_busy0", 32'(b.busy), 0);
        chk("rd_we", {29'd0, b.mepc_we, b.mcause_we, b.mstatus_we}, 0);
        chk("rd_redir", 32'(b.redirect_valid), 0);
        chk("rd_addr", b.redirect_addr, RV);
        step();
        rst = 1'b0;
        b.pipe_idle = 1'b1;
        repeat (6) step();
        chk("rd_after_busy", 32'(b.busy), 0);

        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the machine-mode CSR file. Arbitrates between synchronous exceptions (ecall, ebreak), the MRET return and the asynchronous timer and external interrupt lines, then stalls the pipeline, waits for drain, and drives the CSR write strobes and the PC redirect in a fixed multi-cycle sequence. Sits between the decode/retire stage and the CSR register file and replaces the CSR file's single-cycle combinational interrupt decision.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, value of `redirect_addr` in reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc  in  32  PC of the instruction at the trap point; captured on acceptance.
- ei_n  in  1  external interrupt, active low, asynchronous to clk.
- ti_n  in  1  timer interrupt, active low, asynchronous to clk.
- exc_ecall  in  1  one-cycle pulse, ecall decoded.
- exc_ebreak  in  1  one-cycle pulse, ebreak decoded.
- mret_req  in  1  one-cycle pulse, mret decoded.
- pipe_idle  in  1  high when no instruction is in flight past decode.
- mtvec  in  32  current mtvec CSR.
- mepc  in  32  current mepc CSR.
- mie_meie, mie_mtie  in  1 each  mie[11], mie[7].
- mstatus_mie, mstatus_mpie  in  1 each  mstatus[3], mstatus[7].
- stall  out  1  freeze fetch/decode.
- redirect_valid  out  1  one-cycle pulse, load `redirect_addr` into PC.
- redirect_addr  out  32  target PC.
- mepc_we  out  1  write strobe; `mepc_wdata` out 32.
- mcause_we  out  1  write strobe; `mcause_wdata` out 32.
- mstatus_we  out  1  write strobe; `mie_wdata`, `mpie_wdata` out 1 each.
- busy  out  1  FSM not in IDLE.

## Operation
- ei_n, ti_n each pass a 2-flop synchronizer, flops reset to 1. Pending: ip_e = ~ei_sync & mie_meie & mstatus_mie; ip_t = ~ti_sync & mie_mtie & mstatus_mie.
- Priority in IDLE, highest first: ecall (cause 32'h0000_000B), ebreak (32'h0000_0003), mret, timer (32'h8000_0007), external (32'h8000_000B). Exceptions are not gated by MIE.
- States: IDLE, DRAIN, SAVE, JUMP, RET.
- IDLE: on any accepted event capture cause, {pc[31:2],2'b00} and kind; trap -> DRAIN, mret -> RET.
- DRAIN: stall=1; hold until pipe_idle=1, then -> SAVE.
- SAVE: one cycle; mepc_we=mcause_we=mstatus_we=1; mpie_wdata=mstatus_mie, mie_wdata=0; -> JUMP.
- JUMP: one cycle; redirect_valid=1, redirect_addr={mtvec[31:2],2'b00}; -> IDLE.
- RET: one cycle; stall=1, mstatus_we=1, mie_wdata=mstatus_mpie, mpie_wdata=1, redirect_valid=1, redirect_addr=mepc; -> IDLE.
- exc_*/mret_req outside IDLE are ignored (pipeline is stalled; bench asserts they never occur).
- Interrupt deassertion after acceptance does not abort the trap.

## Timing
- Reset: state IDLE, all strobes 0, stall=0, busy=0, redirect_addr=RESET_VEC, wdata outputs 0, synchronizers 1.
- Outputs are registered from state; request in cycle N -> stall/busy high in N+1.
- With pipe_idle already high: SAVE at N+2, redirect_valid at N+3, stall low at N+4.
- stall high in DRAIN, SAVE, JUMP, RET; low in IDLE.
- Interrupt line to pending: 2 cycles synchronizer latency.
- mret: redirect_valid at N+1, IDLE at N+2; an interrupt enabled by the restored MIE is taken no earlier than N+3.
- Interrupt and mret in same cycle: mret wins; interrupt re-evaluated in IDLE.
- rst mid-sequence: immediately to IDLE, strobes drop, no partial CSR write completes after rst.

## Configuration
- TRAP_VECTORED_EN defined: when mtvec[1:0]==2'b01, interrupts redirect to {mtvec[31:2],2'b00} + 4*cause[4:0]; exceptions always use base.
- Undefined: mtvec[1:0] ignored, all traps go to base (direct mode only).

## Test plan
- mtvec=32'h100, pc=32'h204, pulse exc_ecall, pipe_idle=1 -> SAVE writes mepc=32'h204, mcause=32'hB, mie_wdata=0; redirect to 32'h100 three cycles later.
- mstatus_mie=1, mie_mtie=1, ti_n low, pipe_idle low 5 cycles -> stall held through DRAIN, mcause=32'h8000_0007, redirect after pipe_idle rises.
- ei_n and ti_n low together, both enabled -> timer taken first (mcause 32'h8000_0007).
- mret_req with mepc=32'h3C0, mstatus_mpie=1 -> redirect_valid next cycle to 32'h3C0, mie_wdata=1, mpie_wdata=1.
- TRAP_VECTORED_EN, mtvec=32'h101, external interrupt -> redirect_addr=32'h12C; without macro -> 32'h100.
- rst asserted in DRAIN -> stall, busy, strobes 0 same cycle; no redirect afterward.
